// File: rtl/seq_div_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : seq_div_pkg
// Description : Shared types and constants for the iterative divider.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_div_pkg;

    localparam int unsigned DIV_XLEN    = 32;
    localparam int unsigned DIV_LATENCY = DIV_XLEN + 2;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } div_state_e;

endpackage
`default_nettype wire

// File: rtl/seq_div_div_step.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : div_step
// Description : One combinational radix-2 restoring division iteration.
// Revision    : 1.0 - initial release
// ============================================================================
module div_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] i_rem,
    input  logic [XLEN-1:0] i_quo,
    input  logic [XLEN-1:0] i_divisor,
    output logic [XLEN-1:0] o_rem,
    output logic [XLEN-1:0] o_quo
);

    logic [XLEN:0] w_rem_sh;
    logic [XLEN:0] w_diff;

    // The partial remainder is one bit wider so the trial subtract's sign is exact.
    assign w_rem_sh = {i_rem, i_quo[XLEN-1]};
    assign w_diff   = w_rem_sh - {1'b0, i_divisor};

    assign o_rem = w_diff[XLEN] ? w_rem_sh[XLEN-1:0] : w_diff[XLEN-1:0];
    assign o_quo = {i_quo[XLEN-2:0], ~w_diff[XLEN]};

endmodule
`default_nettype wire

// File: rtl/seq_div.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : seq_div
// Description : Iterative restoring divider for DIV/DIVU/REM/REMU.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_div
    import seq_div_pkg::*;
#(
    parameter int unsigned XLEN = DIV_XLEN
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic            kill_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic            busy_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o
);

    localparam int unsigned c_cnt_w = $clog2(XLEN);

    div_state_e          r_state;
    div_state_e          w_state_nxt;
    logic                r_is_rem;
    logic                r_neg_q;
    logic                r_neg_r;
    logic [XLEN-1:0]     r_rem;
    logic [XLEN-1:0]     r_quo;
    logic [XLEN-1:0]     r_divisor;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [XLEN-1:0]     r_result;

    logic                w_accept;
    logic                w_signed;
    logic                w_a_neg;
    logic                w_b_neg;
    logic [XLEN-1:0]     w_a_mag;
    logic [XLEN-1:0]     w_b_mag;
    logic                w_div_zero;
    logic                w_ovf;
    logic [XLEN-1:0]     w_special_res;
    logic [XLEN-1:0]     w_step_rem;
    logic [XLEN-1:0]     w_step_quo;
    logic [XLEN-1:0]     w_quo_fix;
    logic [XLEN-1:0]     w_rem_fix;

    assign w_accept   = (r_state == IDLE) && start_i && !kill_i;
    assign w_signed   = !op_i[0];
    assign w_a_neg    = w_signed && dividend_i[XLEN-1];
    assign w_b_neg    = w_signed && divisor_i[XLEN-1];
    assign w_a_mag    = w_a_neg ? -dividend_i : dividend_i;
    assign w_b_mag    = w_b_neg ? -divisor_i  : divisor_i;
    assign w_div_zero = (divisor_i == '0);
    assign w_ovf      = w_signed && (dividend_i == {1'b1, {(XLEN-1){1'b0}}}) && (&divisor_i);

    // Results that bypass the iteration entirely.
    always_comb begin
        w_special_res = '0;
        if (w_div_zero)
            w_special_res = op_i[1] ? dividend_i : '1;
        else if (w_ovf)
            w_special_res = op_i[1] ? '0 : dividend_i;
    end

    div_step #(
        .XLEN      (XLEN)
    ) u_div_step (
        .i_rem     (r_rem),
        .i_quo     (r_quo),
        .i_divisor (r_divisor),
        .o_rem     (w_step_rem),
        .o_quo     (w_step_quo)
    );

    assign w_quo_fix = r_neg_q ? -r_quo : r_quo;
    assign w_rem_fix = r_neg_r ? -r_rem : r_rem;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        busy_o      = (r_state != IDLE);
        valid_o     = (r_state == DONE) && !kill_i;
        case (r_state)
            IDLE: if (w_accept) w_state_nxt = (w_div_zero || w_ovf) ? DONE : CALC;
            CALC: if (r_cnt == '0) w_state_nxt = FIX;
            FIX:  w_state_nxt = DONE;
            DONE: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (kill_i)
            w_state_nxt = IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_is_rem  <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            r_cnt     <= '0;
            r_result  <= '0;
        end else if (w_accept) begin
            r_is_rem  <= op_i[1];
            r_neg_q   <= w_a_neg ^ w_b_neg;
            r_neg_r   <= w_a_neg;
            r_rem     <= '0;
            r_quo     <= w_a_mag;
            r_divisor <= w_b_mag;
            r_cnt     <= c_cnt_w'(XLEN - 1);
            if (w_div_zero || w_ovf)
                r_result <= w_special_res;
        end else if (r_state == CALC) begin
            r_rem <= w_step_rem;
            r_quo <= w_step_quo;
            r_cnt <= r_cnt - 1'b1;
        end else if (r_state == FIX && !kill_i) begin
            r_result <= r_is_rem ? w_rem_fix : w_quo_fix;
        end
    end

    assign result_o = r_result;

endmodule
`default_nettype wire

// File: doc/seq_div.md
Name: seq_div

Overview:
- Iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU operations.
- Sequential counterpart to the single-cycle tree multiplier in the mul_div unit.
- Sits beside the multiplier in the execute stage.
- Start/valid handshake; the core stalls on busy_o.

Parameters:
- XLEN, 32, operand and result width in bits (power of two, >= 8)

Ports:
- clk_i  input  1  clock, rising-edge.
- rst_ni  input  1  reset, asynchronous, active-low.
- start_i  input  1  request; accepted only when busy_o=0.
- kill_i  input  1  pipeline flush; aborts any operation in flight.
- op_i  input  2  div_op_e: DIV=00, DIVU=01, REM=10, REMU=11; sampled on accept.
- dividend_i  input  XLEN  rs1; sampled on accept.
- divisor_i  input  XLEN  rs2; sampled on accept.
- busy_o  output  1  operation in flight (states CALC, FIX, DONE).
- valid_o  output  1  result_o valid; single-cycle pulse.
- result_o  output  XLEN  quotient or remainder; held until the next accept.

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-low (clk_i, rst_ni).
- Reset values: state=IDLE, busy_o=0, valid_o=0, result_o=0, counter=0.
- States: IDLE, CALC, FIX, DONE.
- Accept: IDLE & start_i & !kill_i.
  - Registers op, sign flags, |dividend|, |divisor|.
  - Unsigned ops use raw values; signed ops take two's-complement magnitudes.
- Special cases, detected at accept; state goes straight to DONE, so valid_o rises 1 cycle after accept:
  - Divisor == 0: quotient = all ones; remainder = dividend.
  - Signed overflow (dividend = 1 followed by XLEN-1 zeros, i.e. most negative, divisor = -1): quotient = dividend; remainder = 0.
- Normal path, IDLE -> CALC:
  - Counter loads XLEN-1.
  - Each CALC cycle shifts the {rem, quo} pair left by 1 and trial-subtracts the divisor from rem (XLEN+1-bit subtract).
  - If the result is non-negative: commit it, quo LSB=1; otherwise restore, quo LSB=0.
  - Counter decrements each cycle; when it reaches 0, the next state is FIX.
- FIX (1 cycle): sign correction.
  - Quotient is negated if the dividend and divisor signs differ (signed op).
  - Remainder takes the dividend's sign (signed op).
  - Selects quotient or remainder per op into result_o.
- DONE (1 cycle): valid_o=1, then IDLE.
- Latency, accept to valid_o: XLEN+2 cycles normal (34 at XLEN=32); 1 cycle for special cases.
- Throughput:
  - A new start_i is accepted in the cycle after DONE at the earliest (state back in IDLE).
  - start_i while busy_o=1 is ignored; no queueing.
- kill_i:
  - Any state -> IDLE next cycle.
  - busy_o=0 next cycle; valid_o suppressed, including in the DONE cycle itself.
  - result_o unchanged.
  - start_i in the same cycle as kill_i is not accepted.
- Reset mid-operation: immediate return to reset values; no valid_o.
- Width rules:
  - Magnitudes are XLEN bits unsigned; the most-negative magnitude is representable as unsigned 2^(XLEN-1).
  - Partial remainder is XLEN+1 bits.
  - Negation wraps modulo 2^XLEN.
- result_o changes only at FIX (normal path) or at accept (special cases).

Decomposition:
- Package entries (mul_div pkg):
  - typedef enum logic [1:0] div_op_e {DIV, DIVU, REM, REMU}.
  - typedef enum logic [1:0] div_state_e {IDLE, CALC, FIX, DONE}.
  - localparam DIV_LATENCY = XLEN+2.
- One natural sub-module: div_step, a combinational single restoring iteration.
  - Inputs: rem, quo, divisor.
  - Outputs: next rem, quo.
- Core FSM and datapath registers stay in seq_div.

Test Plan:
- DIVU 100/7 -> valid_o exactly 34 cycles after accept, result_o=14; REMU 100/7 -> 2.
- DIV -7/2 -> 0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1); REM 7/-2 -> 1.
- DIV 5/0 -> 0xFFFFFFFF, valid_o 1 cycle after accept; REMU 5/0 -> 5.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, 1-cycle latency; REM of the same -> 0.
- start DIVU 100/7, kill_i at cycle 10 -> busy_o=0 next cycle, no valid_o, result_o unchanged; a second start_i raised on the kill cycle and held through a mid-operation busy window is not accepted until IDLE.
- rst_ni low during CALC -> all outputs 0 asynchronously; after release, DIVU 0xFFFFFFFF/1 -> 0xFFFFFFFF.
